// File: rtl/counter_bank_pkg.sv
// Shared encodings for the counter bank: channel modes, write-select codes
// and control-word bit positions.
package counter_bank_pkg;

    typedef enum logic [1:0] {
        MODE_OFF      = 2'b00,
        MODE_ONESHOT  = 2'b01,
        MODE_PERIODIC = 2'b10,
        MODE_PWM      = 2'b11
    } mode_t;

    typedef enum logic [1:0] {
        SEL_RELOAD = 2'd0,
        SEL_CTRL   = 2'd1,
        SEL_CMP    = 2'd2,
        SEL_IRQCLR = 2'd3
    } sel_t;

    localparam int CTRL_MODE_LSB  = 0;
    localparam int CTRL_IRQEN_BIT = 2;
    localparam int CTRL_PRESC_LSB = 8;
    localparam int PRESC_W        = 8;

    // Channel index width; a single-channel bank still carries a 1-bit index.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/counter_bank_if.sv
// Register bus between the MIO decoder (master) and the counter bank (slave).
interface counter_bank_if #(
    parameter int NUM_CH = 4
);
    localparam int CH_W = counter_bank_pkg::ch_width(NUM_CH);

    // wr_en is a one-cycle strobe with no ready: every strobed write is taken
    // in that cycle. rd_ch is sampled every cycle; rd_data follows one cycle later.
    logic            wr_en;
    logic [CH_W-1:0] wr_ch;
    logic [1:0]      wr_sel;
    logic [31:0]     wr_data;
    logic [CH_W-1:0] rd_ch;
    logic [31:0]     rd_data;

    modport master (
        output wr_en, wr_ch, wr_sel, wr_data, rd_ch,
        input  rd_data
    );

    modport slave (
        input  wr_en, wr_ch, wr_sel, wr_data, rd_ch,
        output rd_data
    );

endinterface

// File: rtl/counter_bank_ch.sv
// One counter channel: tick edge detect, down-counter, sticky flag and PWM.
// Optional prescaler is built only when COUNTER_BANK_PRESCALE_EN is defined.
module counter_bank_ch
    import counter_bank_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_in,
    input  logic             wr,
    input  sel_t             wr_sel,
    input  logic [31:0]      wr_data,
    input  logic             irq_clr,
    output logic [CNT_W-1:0] count,
    output logic             irq,
    output logic             pwm
);

    logic [CNT_W-1:0] reload;
    logic [CNT_W-1:0] compare;
    mode_t            mode;
    logic             irq_en;
    logic             run;
    logic             flag;
    logic             tick_prev;

    logic det_tick;
    logic eff_tick;
    logic terminal;
    logic set_flag;

    // A write to this channel in the same cycle swallows the tick.
    assign det_tick = tick_in && !tick_prev && run && (mode != MODE_OFF) && !wr;

`ifdef COUNTER_BANK_PRESCALE_EN
    logic [PRESC_W-1:0] presc;
    logic [PRESC_W-1:0] presc_cnt;

    assign eff_tick = det_tick && (presc_cnt == presc);

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            presc_cnt <= '0;
        end else if (wr && (wr_sel == SEL_RELOAD || wr_sel == SEL_CTRL)) begin
            presc_cnt <= '0;
            if (wr_sel == SEL_CTRL) presc <= wr_data[CTRL_PRESC_LSB +: PRESC_W];
        end else if (det_tick) begin
            presc_cnt <= eff_tick ? '0 : presc_cnt + 1'b1;
        end
    end
`else
    assign eff_tick = det_tick;
`endif

    assign terminal = eff_tick && (count == '0);
    assign set_flag = terminal && (mode == MODE_ONESHOT || mode == MODE_PERIODIC);
    assign irq      = flag && irq_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            count     <= '0;
            reload    <= '0;
            compare   <= '0;
            mode      <= MODE_OFF;
            irq_en    <= 1'b0;
            run       <= 1'b0;
            flag      <= 1'b0;
            tick_prev <= 1'b0;
            pwm       <= 1'b0;
        end else begin
            tick_prev <= tick_in;
            pwm       <= (mode == MODE_PWM) && run && (count < compare);

            if (set_flag)     flag <= 1'b1;
            else if (irq_clr) flag <= 1'b0;

            if (wr) begin
                case (wr_sel)
                    SEL_RELOAD: begin
                        reload <= wr_data[CNT_W-1:0];
                        count  <= wr_data[CNT_W-1:0];
                        run    <= (mode != MODE_OFF);
                    end
                    SEL_CTRL: begin
                        mode   <= mode_t'(wr_data[CTRL_MODE_LSB +: 2]);
                        irq_en <= wr_data[CTRL_IRQEN_BIT];
                        run    <= (wr_data[CTRL_MODE_LSB +: 2] != MODE_OFF);
                    end
                    SEL_CMP: compare <= wr_data[CNT_W-1:0];
                    default: ;
                endcase
            end else if (eff_tick) begin
                if (count != '0)                count <= count - 1'b1;
                else if (mode == MODE_ONESHOT)  run   <= 1'b0;
                else                            count <= reload;
            end
        end
    end

endmodule

// File: rtl/counter_bank.sv
// NUM_CH-channel down-counter bank: write decode, per-channel instances,
// registered readback and interrupt OR. Optional macro: COUNTER_BANK_PRESCALE_EN.
module counter_bank
    import counter_bank_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] tick_in,
    counter_bank_if.slave     bus,
    output logic [NUM_CH-1:0] irq_out,
    output logic              irq_any,
    output logic [NUM_CH-1:0] pwm_out
);

    localparam int CH_W = ch_width(NUM_CH);

    logic [CNT_W-1:0]  cnt [NUM_CH];
    logic [NUM_CH-1:0] ch_wr;
    logic [NUM_CH-1:0] irq_clr;
    logic [31:0]       rd_next;

    // IRQ clear is a bit mask across all channels and ignores wr_ch.
    always_comb begin
        ch_wr   = '0;
        irq_clr = '0;
        if (bus.wr_en && bus.wr_sel != SEL_IRQCLR) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (bus.wr_ch == CH_W'(i)) ch_wr[i] = 1'b1;
            end
        end
        if (bus.wr_en && bus.wr_sel == SEL_IRQCLR) irq_clr = bus.wr_data[NUM_CH-1:0];
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        counter_bank_ch #(.CNT_W(CNT_W)) u_ch (
            .clk     (clk),
            .rst     (rst),
            .tick_in (tick_in[g]),
            .wr      (ch_wr[g]),
            .wr_sel  (sel_t'(bus.wr_sel)),
            .wr_data (bus.wr_data),
            .irq_clr (irq_clr[g]),
            .count   (cnt[g]),
            .irq     (irq_out[g]),
            .pwm     (pwm_out[g])
        );
    end

    // Out-of-range channel indices match nothing and read back as zero.
    always_comb begin
        rd_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (bus.rd_ch == CH_W'(i)) rd_next[CNT_W-1:0] = cnt[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) bus.rd_data <= '0;
        else     bus.rd_data <= rd_next;
    end

    assign irq_any = |irq_out;

endmodule
